// File: rtl/cpu32_core.sv
// rtl/cpu32_core.sv - 32-bit two-phase (FETCH/EXEC) load/store CPU core
module cpu32_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] d_addr,
    input  logic [31:0] d_data_r,
    output logic [31:0] d_data_w,
    output logic        d_we
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_t;

    localparam logic [3:0] OP_ALUR  = 4'h0;
    localparam logic [3:0] OP_ALUI  = 4'h1;
    localparam logic [3:0] OP_MOVHI = 4'h2;
    localparam logic [3:0] OP_LW    = 4'h3;
    localparam logic [3:0] OP_SW    = 4'h4;
    localparam logic [3:0] OP_BZ    = 4'h5;
    localparam logic [3:0] OP_BNZ   = 4'h6;
    localparam logic [3:0] OP_JAL   = 4'h7;
    localparam logic [3:0] OP_JALR  = 4'h8;

    phase_t      phase, phase_next;
    logic [31:0] pc, pc_next;
    logic [31:0] ir, ir_next;
    logic [31:0] regs [16];

    logic [3:0]  op, rd, ra, rb;
    logic [15:0] imm;
    logic [31:0] simm, br_off;
    logic [31:0] ra_val, rb_val, rd_val;
    logic [3:0]  alu_f;
    logic [31:0] alu_b, alu_y;
    logic        wr_en;
    logic [31:0] wr_data;

    assign op     = ir[31:28];
    assign rd     = ir[27:24];
    assign ra     = ir[23:20];
    assign rb     = ir[19:16];
    assign imm    = ir[15:0];
    assign simm   = {{16{imm[15]}}, imm};
    assign br_off = {simm[29:0], 2'b00};

    assign ra_val = regs[ra];
    assign rb_val = regs[rb];
    assign rd_val = regs[rd];

    // Bus outputs are driven from the current ir at all times, even in FETCH
    assign i_addr   = pc;
    assign d_addr   = ra_val + simm;
    assign d_data_w = rd_val;

    // ALU-I takes the function from the rb field and the immediate as operand b
    always_comb begin
        alu_f = imm[3:0];
        alu_b = rb_val;
        if (op == OP_ALUI) begin
            alu_f = rb;
            alu_b = simm;
        end
    end

    // ALU: mod-2^32 arithmetic, no flags; unused function codes yield zero
    always_comb begin
        alu_y = 32'h0;
        case (alu_f)
            4'h0: alu_y = alu_b;
            4'h1: alu_y = ra_val & alu_b;
            4'h2: alu_y = ra_val | alu_b;
            4'h3: alu_y = ra_val ^ alu_b;
            4'h4: alu_y = ra_val + alu_b;
            4'h5: alu_y = ra_val - alu_b;
            4'h6: alu_y = {31'h0, $signed(ra_val) < $signed(alu_b)};
            4'h7: alu_y = {31'h0, ra_val < alu_b};
            4'h8: alu_y = ra_val << alu_b[4:0];
            4'h9: alu_y = ra_val >> alu_b[4:0];
            4'hA: alu_y = $unsigned($signed(ra_val) >>> alu_b[4:0]);
            default: alu_y = 32'h0;
        endcase
    end

    // Sequencer: next phase, pc, ir, register write and store strobe
    always_comb begin
        phase_next = phase;
        pc_next    = pc;
        ir_next    = ir;
        wr_en      = 1'b0;
        wr_data    = alu_y;
        d_we       = 1'b0;
        if (phase == FETCH) begin
            ir_next    = i_data;
            pc_next    = pc + 32'd4;
            phase_next = EXEC;
        end else begin
            phase_next = FETCH;
            case (op)
                OP_ALUR, OP_ALUI: wr_en = 1'b1;
                OP_MOVHI: begin
                    wr_en   = 1'b1;
                    wr_data = {imm, rd_val[15:0]};
                end
                OP_LW: begin
                    wr_en   = 1'b1;
                    wr_data = d_data_r;
                end
                // A reset arriving in this EXEC cancels the write pulse
                OP_SW: d_we = ~reset;
                OP_BZ: if (rd_val == 32'h0) pc_next = pc + br_off;
                OP_BNZ: if (rd_val != 32'h0) pc_next = pc + br_off;
                OP_JAL: begin
                    wr_en   = 1'b1;
                    wr_data = pc;
                    pc_next = pc + br_off;
                end
                // Target comes from ra_val sampled before the rd write lands
                OP_JALR: begin
                    wr_en   = 1'b1;
                    wr_data = pc;
                    pc_next = {ra_val[31:2], 2'b00};
                end
                default: ;
            endcase
        end
    end

    // State register; reset discards any pending register write
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= FETCH;
            pc    <= RESET_PC;
            ir    <= 32'h0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            phase <= phase_next;
            pc    <= pc_next;
            ir    <= ir_next;
            if (wr_en) begin
                regs[rd] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu32_core.sv
// tb/tb_cpu32_core.sv - scoreboard bench for cpu32_core with ISA-level reference model
module tb_cpu32_core;

    logic        clk;
    logic        reset;
    logic [31:0] i_addr, i_data, d_addr, d_data_r, d_data_w;
    logic        d_we;

    cpu32_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .d_addr   (d_addr),
        .d_data_r (d_data_r),
        .d_data_w (d_data_w),
        .d_we     (d_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rom [64];
    logic [31:0] ram [256];

    assign i_data   = rom[i_addr[7:2]];
    assign d_data_r = ram[d_addr[9:2]];

    always @(posedge clk) begin
        if (d_we) ram[d_addr[9:2]] <= d_data_w;
    end

    int tests = 0;
    int fails = 0;

    logic [31:0] st_a [$];
    logic [31:0] st_d [$];
    logic [31:0] pc_q [$];
    bit          fetch_chk = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [31:0] d);
        st_a.push_back(a);
        st_d.push_back(d);
    endtask

    // Monitor: every store pulse and (optionally) every fetch address is scored
    int ph = 0;
    always @(negedge clk) begin
        if (d_we) begin
            if (st_a.size() == 0) begin
                chk("store_unexpected", d_addr, 32'hxxxx_xxxx);
            end else begin
                chk("store_addr", d_addr, st_a.pop_front());
                chk("store_data", d_data_w, st_d.pop_front());
            end
        end
        if (reset) begin
            ph = 0;
        end else begin
            if (ph == 0 && fetch_chk) begin
                if (pc_q.size() == 0) chk("fetch_unexpected", i_addr, 32'hxxxx_xxxx);
                else chk("fetch_pc", i_addr, pc_q.pop_front());
            end
            ph = 1 - ph;
        end
    end

    // Reference model: instruction-at-a-time interpreter
    logic [31:0] m_r [16];
    logic [31:0] m_pc;
    logic [31:0] m_ram [256];

    function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'h0: return b;
            4'h1: return a & b;
            4'h2: return a | b;
            4'h3: return a ^ b;
            4'h4: return a + b;
            4'h5: return a - b;
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return a << b[4:0];
            4'h9: return a >> b[4:0];
            4'hA: return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] w, s, a, t;
        logic [3:0]  o, d, x, y;
        pc_q.push_back(m_pc);
        w = rom[m_pc[7:2]];
        m_pc = m_pc + 32'd4;
        o = w[31:28]; d = w[27:24]; x = w[23:20]; y = w[19:16];
        s = {{16{w[15]}}, w[15:0]};
        a = m_r[x] + s;
        case (o)
            4'h0: m_r[d] = alu(w[3:0], m_r[x], m_r[y]);
            4'h1: m_r[d] = alu(y, m_r[x], s);
            4'h2: m_r[d] = {w[15:0], m_r[d][15:0]};
            4'h3: m_r[d] = m_ram[a[9:2]];
            4'h4: begin
                exp_store(a, m_r[d]);
                m_ram[a[9:2]] = m_r[d];
            end
            4'h5: if (m_r[d] == 0) m_pc = m_pc + s * 4;
            4'h6: if (m_r[d] != 0) m_pc = m_pc + s * 4;
            4'h7: begin
                m_r[d] = m_pc;
                m_pc = m_pc + s * 4;
            end
            4'h8: begin
                t = m_r[x];
                m_r[d] = m_pc;
                m_pc = t & 32'hFFFF_FFFC;
            end
            default: ;
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [15:0] off;
        int k;
        k = $urandom_range(0, 15);
        r = $urandom;
        off = 16'($urandom_range(0, 8)) - 16'd4;
        case (k)
            0, 1, 2:  return {4'h0, r[27:16], r[15:4], r[3:0]};
            3, 4, 5:  return {4'h1, r[27:0]};
            6:        return {4'h2, r[27:0]};
            7:        return {4'h3, r[27:0]};
            8, 9, 10: return {4'h4, r[27:0]};
            11:       return {4'h5, r[27:16], off};
            12:       return {4'h6, r[27:16], off};
            13:       return {4'h7, r[27:16], off};
            14:       return {4'h8, r[27:0]};
            default:  return r;
        endcase
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 32'hF000_0000;
    endtask

    task automatic hold_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_run(input int n);
        reset = 1'b0;
        repeat (2 * n) @(posedge clk);
        #1 reset = 1'b1;
        chk("missing_stores", 32'(st_a.size()), 32'd0);
        chk("missing_fetches", 32'(fetch_chk ? pc_q.size() : 0), 32'd0);
        st_a.delete(); st_d.delete(); pc_q.delete();
        fetch_chk = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_rom();
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // Reset state
        hold_reset();
        chk("reset_pc", i_addr, 32'h0);
        chk("reset_we", {31'h0, d_we}, 32'h0);

        // Character-port store: R2=0xE0000000, R1=0x41, SW R1->[R2]
        clear_rom();
        rom[0] = 32'h2200_E000;
        rom[1] = 32'h1100_0041;
        rom[2] = 32'h4120_0000;
        exp_store(32'hE000_0000, 32'h0000_0041);
        release_run(3);

        // ALU patterns
        hold_reset();
        clear_rom();
        rom[0]  = 32'h2300_1234;
        rom[1]  = 32'h1332_0678;
        rom[2]  = 32'h4300_0040;
        rom[3]  = 32'h0433_0005;
        rom[4]  = 32'h4400_0044;
        rom[5]  = 32'h1500_FFFF;
        rom[6]  = 32'h1600_0001;
        rom[7]  = 32'h0756_0006;
        rom[8]  = 32'h4700_0048;
        rom[9]  = 32'h0856_0007;
        rom[10] = 32'h4800_004C;
        rom[11] = 32'h2900_8000;
        rom[12] = 32'h1A9A_0004;
        rom[13] = 32'h4A00_0050;
        exp_store(32'h40, 32'h1234_0678);
        exp_store(32'h44, 32'h0000_0000);
        exp_store(32'h48, 32'h0000_0001);
        exp_store(32'h4C, 32'h0000_0000);
        exp_store(32'h50, 32'hF800_0000);
        release_run(14);

        // Store then load back through RAM
        hold_reset();
        clear_rom();
        rom[0] = 32'h1100_BEEF;
        rom[1] = 32'h2100_DEAD;
        rom[2] = 32'h4100_0010;
        rom[3] = 32'h3500_0010;
        rom[4] = 32'h4500_0014;
        exp_store(32'h10, 32'hDEAD_BEEF);
        exp_store(32'h14, 32'hDEAD_BEEF);
        release_run(5);

        // Branch loop, BZ not taken, JAL/JALR, reserved and 0xF words
        hold_reset();
        clear_rom();
        rom[0]  = 32'h1100_0002;
        rom[1]  = 32'h1114_FFFF;
        rom[2]  = 32'h1224_0001;
        rom[3]  = 32'h6100_FFFD;
        rom[4]  = 32'h4200_0060;
        rom[5]  = 32'h5200_0005;
        rom[6]  = 32'h4100_0064;
        rom[7]  = 32'h9000_0000;
        rom[8]  = 32'h7F00_0004;
        rom[9]  = 32'h4E00_006C;
        rom[10] = 32'hFFFF_FFFF;
        rom[11] = 32'hF110_0001;
        rom[12] = 32'h4100_0070;
        rom[13] = 32'h4F00_0068;
        rom[14] = 32'h8EF0_0000;
        fetch_chk = 1;
        foreach (pc_q[i]) pc_q[i] = 32'h0;
        pc_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                 32'h18, 32'h1C, 32'h20, 32'h34, 32'h38, 32'h24, 32'h28, 32'h2C, 32'h30};
        exp_store(32'h60, 32'h2);
        exp_store(32'h64, 32'h0);
        exp_store(32'h68, 32'h24);
        exp_store(32'h6C, 32'h3C);
        exp_store(32'h70, 32'h0);
        release_run(18);

        // Reset during EXEC of a store: no pulse, registers cleared, pc restarts
        hold_reset();
        clear_rom();
        rom[0] = 32'h1100_0007;
        rom[1] = 32'h4100_0020;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_we", {31'h0, d_we}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pc", i_addr, 32'h0);
        rom[0] = 32'h4100_0024;
        exp_store(32'h24, 32'h0);
        release_run(1);

        // Randomized programs against the reference model
        for (int t = 0; t < 6; t++) begin
            hold_reset();
            for (int i = 0; i < 64; i++) rom[i] = rand_instr();
            for (int i = 0; i < 256; i++) begin
                ram[i] = $urandom;
                m_ram[i] = ram[i];
            end
            for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
            m_pc = 32'h0;
            fetch_chk = 1;
            for (int i = 0; i < 40; i++) model_step();
            release_run(40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
